// File: rtl/one_hot_monitor.sv
// Registered one-hot monitor: classifies each valid sample, encodes the set bit's index,
// keeps saturating error statistics and latches FAULT after ERR_THRESH consecutive illegal samples.
module one_hot_monitor #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int ERR_THRESH = 3,
    parameter int ALLOW_ZERO = 0,
    localparam int IDX_W  = $clog2(DATA_WIDTH),
    localparam int CONS_W = $clog2(ERR_THRESH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    output logic                  valid_out,
    output logic                  detected,
    output logic                  is_zero,
    output logic                  is_multi,
    output logic [IDX_W-1:0]      index,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  fault
);

    localparam logic [0:0]            ST_MONITOR = 1'b0;
    localparam logic [0:0]            ST_FAULT   = 1'b1;
    localparam logic [DATA_WIDTH-1:0] DATA_ONE   = DATA_WIDTH'(1);
    localparam logic [CONS_W-1:0]     THRESH     = CONS_W'(ERR_THRESH);
    localparam logic [CNT_WIDTH-1:0]  ERR_MAX    = '1;

    logic              smp_zero, smp_one, smp_multi, smp_illegal;
    logic [IDX_W-1:0]  smp_idx;
    logic [CONS_W-1:0] cons_cnt, cons_inc;
    logic [0:0]        state, state_nxt;

    // x & (x-1) clears the lowest set bit, so a nonzero result means two or more bits.
    assign smp_zero    = ~|data_in;
    assign smp_one     = ~smp_zero && ((data_in & (data_in - DATA_ONE)) == '0);
    assign smp_multi   = ~smp_zero & ~smp_one;
    assign smp_illegal = smp_multi | (smp_zero & (ALLOW_ZERO == 0));

    // OR of set-bit positions is exact for one-hot input; masked otherwise.
    always_comb begin
        smp_idx = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (data_in[i]) smp_idx = smp_idx | IDX_W'(i);
    end

    assign cons_inc = (cons_cnt == THRESH) ? cons_cnt : cons_cnt + CONS_W'(1);

    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = ST_MONITOR;
        else if (valid_in && smp_illegal && cons_inc == THRESH)
            state_nxt = ST_FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            detected  <= 1'b0;
            is_zero   <= 1'b0;
            is_multi  <= 1'b0;
            index     <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                detected <= smp_one;
                is_zero  <= smp_zero;
                is_multi <= smp_multi;
                index    <= smp_one ? smp_idx : '0;
            end
        end
    end

    // Clear wins over a coincident sample for all statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            cons_cnt   <= '0;
            state      <= ST_MONITOR;
        end else begin
            state <= state_nxt;
            if (clear) begin
                err_count  <= '0;
                err_sticky <= 1'b0;
                cons_cnt   <= '0;
            end else if (valid_in) begin
                if (smp_illegal) begin
                    err_sticky <= 1'b1;
                    cons_cnt   <= cons_inc;
                    if (err_count != ERR_MAX) err_count <= err_count + CNT_WIDTH'(1);
                end else begin
                    cons_cnt <= '0;
                end
            end
        end
    end

    assign fault = (state == ST_FAULT);

endmodule

// File: tb/tb_one_hot_monitor.sv
// Directed bench for one_hot_monitor: three instances cover the default config,
// ALLOW_ZERO=1, and CNT_WIDTH=2 / ERR_THRESH=1.
module tb_one_hot_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // instance a: defaults
    logic       va = 0, ca = 0;
    logic [7:0] da = 0;
    logic       a_vo, a_det, a_zero, a_multi, a_sticky, a_fault;
    logic [2:0] a_idx;
    logic [15:0] a_cnt;
    one_hot_monitor a (
        .clk(clk), .rst_n(rst_n), .valid_in(va), .data_in(da), .clear(ca),
        .valid_out(a_vo), .detected(a_det), .is_zero(a_zero), .is_multi(a_multi),
        .index(a_idx), .err_sticky(a_sticky), .err_count(a_cnt), .fault(a_fault));

    // instance b: zero is legal
    logic       vb = 0, cb = 0;
    logic [7:0] db = 0;
    logic       b_vo, b_det, b_zero, b_multi, b_sticky, b_fault;
    logic [2:0] b_idx;
    logic [15:0] b_cnt;
    one_hot_monitor #(.ALLOW_ZERO(1)) b (
        .clk(clk), .rst_n(rst_n), .valid_in(vb), .data_in(db), .clear(cb),
        .valid_out(b_vo), .detected(b_det), .is_zero(b_zero), .is_multi(b_multi),
        .index(b_idx), .err_sticky(b_sticky), .err_count(b_cnt), .fault(b_fault));

    // instance c: narrow counter, single-sample fault
    logic       vc = 0, cc = 0;
    logic [7:0] dc = 0;
    logic       c_vo, c_det, c_zero, c_multi, c_sticky, c_fault;
    logic [2:0] c_idx;
    logic [1:0] c_cnt;
    one_hot_monitor #(.CNT_WIDTH(2), .ERR_THRESH(1)) c (
        .clk(clk), .rst_n(rst_n), .valid_in(vc), .data_in(dc), .clear(cc),
        .valid_out(c_vo), .detected(c_det), .is_zero(c_zero), .is_multi(c_multi),
        .index(c_idx), .err_sticky(c_sticky), .err_count(c_cnt), .fault(c_fault));

    // expected detected-index triples for test 1
    logic [7:0] t1_dat [3] = '{8'h01, 8'h08, 8'h80};
    logic [2:0] t1_idx [3] = '{3'd0, 3'd3, 3'd7};
    // test 3 sequence with expected err_count, consecutive count and fault after each
    logic [7:0] t3_dat [6] = '{8'h03, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h11};
    logic [15:0] t3_cnt [6] = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4, 16'd5};
    logic [1:0] t3_cons [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       t3_flt [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #2;
        chk("rst_vo", a_vo, 0);       chk("rst_det", a_det, 0);
        chk("rst_zero", a_zero, 0);   chk("rst_multi", a_multi, 0);
        chk("rst_idx", a_idx, 0);     chk("rst_sticky", a_sticky, 0);
        chk("rst_cnt", a_cnt, 0);     chk("rst_fault", a_fault, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // 1: one-hot samples
        for (int i = 0; i < 3; i++) begin
            va = 1; da = t1_dat[i];
            step();
            chk($sformatf("t1_vo%0d", i), a_vo, 1);
            chk($sformatf("t1_det%0d", i), a_det, 1);
            chk($sformatf("t1_idx%0d", i), a_idx, t1_idx[i]);
            chk($sformatf("t1_cnt%0d", i), a_cnt, 0);
            chk($sformatf("t1_fault%0d", i), a_fault, 0);
        end

        // 2: multi-hot then idle
        da = 8'h12;
        step();
        chk("t2_multi", a_multi, 1); chk("t2_det", a_det, 0); chk("t2_idx", a_idx, 0);
        chk("t2_cnt", a_cnt, 1);     chk("t2_sticky", a_sticky, 1);
        va = 0; da = 8'h04;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t2_idle_vo%0d", i), a_vo, 0);
            chk($sformatf("t2_idle_multi%0d", i), a_multi, 1);
            chk($sformatf("t2_idle_cnt%0d", i), a_cnt, 1);
            chk($sformatf("t2_idle_cons%0d", i), a.cons_cnt, 1);
        end

        // clear with no sample: stats zeroed, classification held
        ca = 1;
        step();
        ca = 0;
        chk("clr_cnt", a_cnt, 0); chk("clr_sticky", a_sticky, 0);
        chk("clr_multi", a_multi, 1); chk("clr_cons", a.cons_cnt, 0);

        // 3: consecutive counter and fault
        va = 1;
        for (int i = 0; i < 6; i++) begin
            da = t3_dat[i];
            step();
            chk($sformatf("t3_cnt%0d", i), a_cnt, t3_cnt[i]);
            chk($sformatf("t3_cons%0d", i), a.cons_cnt, t3_cons[i]);
            chk($sformatf("t3_fault%0d", i), a_fault, t3_flt[i]);
        end
        da = 8'h04;
        step();
        chk("t3_hold_fault", a_fault, 1); chk("t3_hold_det", a_det, 1);
        chk("t3_hold_idx", a_idx, 2);     chk("t3_hold_cnt", a_cnt, 5);
        chk("t3_hold_cons", a.cons_cnt, 0);

        // 5: clear with illegal sample while in FAULT
        ca = 1; da = 8'hC0;
        step();
        ca = 0; va = 0;
        chk("t5_vo", a_vo, 1);       chk("t5_multi", a_multi, 1);
        chk("t5_fault", a_fault, 0); chk("t5_cnt", a_cnt, 0);
        chk("t5_sticky", a_sticky, 0); chk("t5_cons", a.cons_cnt, 0);

        // 4: ALLOW_ZERO=1
        vb = 1; db = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t4_zero%0d", i), b_zero, 1);
            chk($sformatf("t4_cnt%0d", i), b_cnt, 0);
        end
        vb = 0;
        chk("t4_sticky", b_sticky, 0); chk("t4_fault", b_fault, 0); chk("t4_det", b_det, 0);

        // 6: ERR_THRESH=1 latency and CNT_WIDTH=2 saturation
        vc = 1; dc = 8'h00;
        step();
        chk("t6_fault1", c_fault, 1); chk("t6_cnt1", c_cnt, 1);
        dc = 8'h0F;
        for (int i = 2; i <= 6; i++) begin
            step();
            chk($sformatf("t6_cnt%0d", i), c_cnt, (i > 3) ? 3 : i);
        end
        chk("t6_multi", c_multi, 1);

        // asynchronous reset away from any edge
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("ar_c_vo", c_vo, 0);     chk("ar_c_multi", c_multi, 0);
        chk("ar_c_cnt", c_cnt, 0);   chk("ar_c_sticky", c_sticky, 0);
        chk("ar_c_fault", c_fault, 0); chk("ar_c_state", c.state, 0);
        chk("ar_c_cons", c.cons_cnt, 0);
        chk("ar_a_multi", a_multi, 0);
        vc = 0;
        #20 rst_n = 1;
        step();
        chk("post_rst_fault", c_fault, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/one_hot_monitor.md
Name: one_hot_monitor

Overview:
Registered, parametrised successor to the combinational one-hot detector. It classifies each valid sample of a DATA_WIDTH-bit vector as one-hot, zero or multi-hot, and encodes the index of the set bit. It also accumulates error statistics and escalates to a latched FAULT state after ERR_THRESH consecutive illegal samples. It sits on one-hot buses such as arbiter grants, FSM state vectors and mux selects, and feeds status or interrupt logic.

Parameters:
DATA_WIDTH, 8, width of monitored vector (legal range >= 2)
CNT_WIDTH, 16, width of the saturating error counter
ERR_THRESH, 3, consecutive illegal valid samples that cause FAULT (legal range >= 1)
ALLOW_ZERO, 0, 1 = an all-zero sample is legal, not counted as an error

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
valid_in  input  1  data_in is a sample this cycle
data_in  input  DATA_WIDTH  monitored vector
clear  input  1  synchronous clear of statistics and FAULT
valid_out  output  1  classification outputs updated this cycle
detected  output  1  last valid sample had exactly one bit set
is_zero  output  1  last valid sample was all zeros
is_multi  output  1  last valid sample had two or more bits set
index  output  $clog2(DATA_WIDTH)  bit position of the set bit when detected, else 0
err_sticky  output  1  at least one illegal sample since reset or clear
err_count  output  CNT_WIDTH  number of illegal samples, saturating
fault  output  1  high while the FSM is in FAULT

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, the consecutive counter is 0 and the FSM is in MONITOR. Assertion mid-operation takes effect immediately.
- Latency: 1 cycle. valid_out equals valid_in from the previous cycle. detected, is_zero, is_multi and index update only on a valid sample.
- When valid_in is low, the classification outputs hold their last values and valid_out is 0 in the following cycle.
- Classification: exactly one of detected, is_zero and is_multi is set after the first valid sample. index is the binary position of the single 1, for example 8'b0000_1000 gives 3. index is 0 for zero or multi-hot samples.
- A sample is illegal when is_multi is set, or when it is all zero and ALLOW_ZERO = 0.
- err_count increments by 1 on each illegal valid sample and saturates at 2^CNT_WIDTH-1; it never wraps.
- err_sticky is set on the first illegal valid sample.
- Consecutive counter, width $clog2(ERR_THRESH+1):
  - increments on an illegal valid sample and saturates at ERR_THRESH;
  - resets to 0 on a legal valid sample;
  - holds on cycles where valid_in is low.
- FSM has two states, MONITOR and FAULT:
  - MONITOR -> FAULT in the cycle the consecutive counter reaches ERR_THRESH; fault rises together with the valid_out for that sample.
  - FAULT holds regardless of later legal samples and leaves only on clear or reset.
  - In FAULT, classification and err_count keep updating normally.
- clear, synchronous, takes effect at the next edge:
  - zeroes err_count, err_sticky and the consecutive counter, and sets the FSM to MONITOR;
  - does not alter detected, is_zero, is_multi or index.
- clear together with valid_in:
  - the sample is still classified and valid_out asserts;
  - clear has priority for the statistics, so the sample is not counted and cannot trigger FAULT.
- ERR_THRESH = 1: the first illegal sample enters FAULT with 1-cycle latency.

Test Plan:
1. Reset, then valid samples 8'h01, 8'h08, 8'h80 -> detected = 1 with index 0, 3, 7 on consecutive cycles; valid_out = 1 one cycle after each; err_count = 0; fault = 0.
2. Valid 8'h12, then valid_in low for 2 cycles -> is_multi = 1, index = 0, err_count = 1, err_sticky = 1. Outputs hold during the idle cycles and valid_out = 0 there.
3. ERR_THRESH = 3: valid 8'h03, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h11 with ALLOW_ZERO = 0:
   - the consecutive counter resets at 8'h01;
   - fault rises on the output cycle for 8'h11;
   - err_count = 5;
   - a following 8'h04 keeps fault = 1.
4. ALLOW_ZERO = 1: 4 valid samples of 8'h00 -> is_zero = 1, err_count = 0, err_sticky = 0, fault = 0.
5. From FAULT, pulse clear together with valid 8'hC0 -> next cycle is_multi = 1, fault = 0, err_count = 0, err_sticky = 0, consecutive counter = 0.
6. CNT_WIDTH = 2 with 6 illegal samples -> err_count saturates at 3. Asserting rst_n low mid-stream immediately zeroes all outputs and the FSM returns to MONITOR.
